// File: rtl/wb_queue_if.sv
// Bus bundle for wb_queue: producer results, register-file write port, queue
// occupancy and forwarding lookup. master = surrounding pipeline, slave = queue.
interface wb_queue_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   parameter int AW    = 5
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             mem_valid;
   logic [AW-1:0]    mem_rd;
   logic [WIDTH-1:0] mem_data;
   logic             alu_valid;
   logic [AW-1:0]    alu_rd;
   logic [WIDTH-1:0] alu_data;
   logic             in_ready;
   logic [AW-1:0]    Write_register;
   logic [WIDTH-1:0] Write_data;
   logic             RegWrite;
   logic [CW-1:0]    wbq_count;
   logic [AW-1:0]    rs1;
   logic [AW-1:0]    rs2;
   logic             fwd_hit1;
   logic             fwd_hit2;
   logic [WIDTH-1:0] fwd_data1;
   logic [WIDTH-1:0] fwd_data2;

   modport master (
      output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, rs1, rs2,
      input  in_ready, Write_register, Write_data, RegWrite, wbq_count,
             fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
   );

   modport slave (
      input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, rs1, rs2,
      output in_ready, Write_register, Write_data, RegWrite, wbq_count,
             fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
   );
endinterface

// File: rtl/wb_queue.sv
// In-order write-back queue driving a single edge-triggered register-file port.
// Define WBQ_FWD_EN to build the forwarding lookup over pending writes.
module wb_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   parameter int AW    = 5
) (
   input logic        clk,
   input logic        rst,
   wb_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {ISSUE, GAP} state_t;

   state_t           state_reg;
   logic [AW-1:0]    rd_q   [DEPTH];
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [PW-1:0]    head_reg;
   logic [PW-1:0]    tail_reg;
   logic [CW-1:0]    count_reg;
   logic [AW-1:0]    wreg_reg;
   logic [WIDTH-1:0] wdata_reg;
   logic             regwrite_reg;

   logic             in_ready;
   logic             mem_acc;
   logic             alu_acc;
   logic             pop;
   logic [1:0]       enq_n;
   logic [PW-1:0]    alu_ptr;
   logic [PW-1:0]    tail_next;
   logic [CW-1:0]    count_next;

   // Readiness looks only at the current count so it never depends on *_valid.
   assign in_ready   = (count_reg <= CW'(DEPTH - 2));
   assign mem_acc    = in_ready & bus.mem_valid;
   assign alu_acc    = in_ready & bus.alu_valid;
   assign enq_n      = {1'b0, mem_acc} + {1'b0, alu_acc};
   assign alu_ptr    = tail_reg + PW'(mem_acc);
   assign tail_next  = tail_reg + PW'(enq_n);
   assign pop        = (state_reg == ISSUE) && (count_reg != '0);
   assign count_next = count_reg + CW'(enq_n) - CW'(pop);

   // mem lands at the tail, alu right behind it, so mem is older on a tie.
   always_ff @(posedge clk) begin
      if (mem_acc) begin
         rd_q[tail_reg]   <= bus.mem_rd;
         data_q[tail_reg] <= bus.mem_data;
      end
      if (alu_acc) begin
         rd_q[alu_ptr]   <= bus.alu_rd;
         data_q[alu_ptr] <= bus.alu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ISSUE;
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         wreg_reg     <= '0;
         wdata_reg    <= '0;
         regwrite_reg <= 1'b0;
      end else begin
         tail_reg  <= tail_next;
         count_reg <= count_next;
         case (state_reg)
            ISSUE: begin
               if (pop) begin
                  wreg_reg     <= rd_q[head_reg];
                  wdata_reg    <= data_q[head_reg];
                  regwrite_reg <= 1'b1;
                  head_reg     <= head_reg + PW'(1);
                  state_reg    <= GAP;
               end else begin
                  regwrite_reg <= 1'b0;
               end
            end
            // The register file is edge-triggered: force a low cycle after each write.
            GAP: begin
               regwrite_reg <= 1'b0;
               state_reg    <= ISSUE;
            end
            default: begin
               regwrite_reg <= 1'b0;
               state_reg    <= ISSUE;
            end
         endcase
      end
   end

   assign bus.in_ready       = in_ready;
   assign bus.wbq_count      = count_reg;
   assign bus.Write_register = wreg_reg;
   assign bus.Write_data     = wdata_reg;
   assign bus.RegWrite       = regwrite_reg;

`ifdef WBQ_FWD_EN
   logic [DEPTH-1:0] match1;
   logic [DEPTH-1:0] match2;
   logic [WIDTH-1:0] ord_data [DEPTH];
   logic             hit1;
   logic             hit2;
   logic [WIDTH-1:0] fdata1;
   logic [WIDTH-1:0] fdata2;

   // Entries re-indexed by age: slot gi is gi places behind the head.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
         logic [PW-1:0] idx;
         logic          live;
         assign idx          = head_reg + PW'(gi);
         assign live         = (CW'(gi) < count_reg);
         assign match1[gi]   = live && (rd_q[idx] == bus.rs1);
         assign match2[gi]   = live && (rd_q[idx] == bus.rs2);
         assign ord_data[gi] = data_q[idx];
      end
   endgenerate

   // The entry on the outputs is the oldest; later queue slots override it.
   always_comb begin
      hit1   = regwrite_reg && (wreg_reg == bus.rs1);
      hit2   = regwrite_reg && (wreg_reg == bus.rs2);
      fdata1 = hit1 ? wdata_reg : '0;
      fdata2 = hit2 ? wdata_reg : '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (match1[i]) begin
            hit1   = 1'b1;
            fdata1 = ord_data[i];
         end
         if (match2[i]) begin
            hit2   = 1'b1;
            fdata2 = ord_data[i];
         end
      end
   end

   assign bus.fwd_hit1  = hit1;
   assign bus.fwd_hit2  = hit2;
   assign bus.fwd_data1 = fdata1;
   assign bus.fwd_data2 = fdata2;
`else
   logic unused_rs;
   assign unused_rs     = ^{bus.rs1, bus.rs2};
   assign bus.fwd_hit1  = 1'b0;
   assign bus.fwd_hit2  = 1'b0;
   assign bus.fwd_data1 = '0;
   assign bus.fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: accepted entries are queued in order and
// popped against every RegWrite pulse predicted by an independent drain model.
module tb_wb_queue;
   localparam int DEPTH = 4;
   localparam int WIDTH = 32;
   localparam int AW    = 5;

   typedef struct packed {
      logic [AW-1:0]    rd;
      logic [WIDTH-1:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) bus ();

   wb_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   ent_t sb[$];
   ent_t last_exp;
   int   model_count;
   logic model_rw;
   logic model_gap;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fwd_expect(input logic [AW-1:0] rs, output logic hit, output logic [WIDTH-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (model_rw && last_exp.rd == rs) begin
         hit = 1'b1;
         d   = last_exp.data;
      end
      foreach (sb[i]) begin
         if (sb[i].rd == rs) begin
            hit = 1'b1;
            d   = sb[i].data;
         end
      end
   endtask

   task automatic check_outputs();
      logic             h1, h2;
      logic [WIDTH-1:0] d1, d2;
      check("in_ready", 64'(bus.in_ready), 64'(model_count <= DEPTH - 2));
      check("wbq_count", 64'(bus.wbq_count), 64'(model_count));
      check("RegWrite", 64'(bus.RegWrite), 64'(model_rw));
      if (model_rw && sb.size() > 0) begin
         last_exp = sb.pop_front();
         $display("write rd=%0d data=%h (dut rd=%0d data=%h)",
                  last_exp.rd, last_exp.data, bus.Write_register, bus.Write_data);
      end
      check("Write_register", 64'(bus.Write_register), 64'(last_exp.rd));
      check("Write_data", 64'(bus.Write_data), 64'(last_exp.data));
      fwd_expect(bus.rs1, h1, d1);
      fwd_expect(bus.rs2, h2, d2);
`ifdef WBQ_FWD_EN
      check("fwd_hit1", 64'(bus.fwd_hit1), 64'(h1));
      check("fwd_hit2", 64'(bus.fwd_hit2), 64'(h2));
      if (h1) check("fwd_data1", 64'(bus.fwd_data1), 64'(d1));
      if (h2) check("fwd_data2", 64'(bus.fwd_data2), 64'(d2));
`else
      check("fwd_hit1_off", 64'(bus.fwd_hit1), 64'(0));
      check("fwd_hit2_off", 64'(bus.fwd_hit2), 64'(0));
      check("fwd_data1_off", 64'(bus.fwd_data1), 64'(0));
`endif
   endtask

   task automatic model_reset();
      model_count = 0;
      model_rw    = 1'b0;
      model_gap   = 1'b0;
      last_exp    = '0;
      sb.delete();
   endtask

   // Called at a negedge: check, drive, cross one rising edge, return at negedge.
   task automatic step(input logic mv, input logic [AW-1:0] mrd, input logic [WIDTH-1:0] md,
                       input logic av, input logic [AW-1:0] ard, input logic [WIDTH-1:0] ad);
      int   enq;
      logic pop_m;
      ent_t e;
      #1;
      check_outputs();
      bus.mem_valid = mv;
      bus.mem_rd    = mrd;
      bus.mem_data  = md;
      bus.alu_valid = av;
      bus.alu_rd    = ard;
      bus.alu_data  = ad;
      enq = 0;
      if (model_count <= DEPTH - 2) begin
         if (mv) begin e.rd = mrd; e.data = md; sb.push_back(e); enq++; end
         if (av) begin e.rd = ard; e.data = ad; sb.push_back(e); enq++; end
      end
      @(posedge clk);
      pop_m       = !model_gap && (model_count > 0);
      model_rw    = pop_m;
      model_gap   = pop_m;
      model_count = model_count + enq - int'(pop_m);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic do_reset(input bit chk);
      #1;
      if (chk) check_outputs();
      rst = 1'b1;
      bus.mem_valid = 1'b0;
      bus.alu_valid = 1'b0;
      @(posedge clk);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
      bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.rs1 = '0; bus.rs2 = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // single alu entry, minimum latency
      bus.rs1 = 5'd3; bus.rs2 = 5'd4;
      step(1'b0, '0, '0, 1'b1, 5'd3, 32'h0000_0006);
      idle(4);

      // simultaneous mem and alu to the same register
      bus.rs1 = 5'd1; bus.rs2 = 5'd2;
      step(1'b1, 5'd1, 32'h9, 1'b1, 5'd1, 32'hA);
      idle(5);

      // dual inputs every cycle: saturation, drops and pointer wrap
      bus.rs1 = 5'd2; bus.rs2 = 5'd5;
      for (int i = 0; i < 14; i++)
         step(1'b1, 5'($urandom_range(0, 7)), 32'h1000 + 32'(2 * i),
              1'b1, 5'($urandom_range(0, 7)), 32'h1000 + 32'(2 * i + 1));
      idle(10);

      // reset with three entries pending and a write on the outputs
      step(1'b1, 5'd7, 32'hAAAA_0001, 1'b1, 5'd8, 32'hAAAA_0002);
      step(1'b1, 5'd9, 32'hAAAA_0003, 1'b1, 5'd10, 32'hAAAA_0004);
      do_reset(1'b1);
      idle(6);

      // register 0 is an ordinary destination
      bus.rs1 = 5'd0; bus.rs2 = 5'd0;
      step(1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_1234);
      idle(5);

      // random mix
      for (int i = 0; i < 40; i++) begin
         bus.rs1 = 5'($urandom_range(0, 3));
         bus.rs2 = 5'($urandom_range(0, 3));
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      end
      idle(14);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue feeding the register file's single write port. It accepts results from the load path and the ALU path, buffers them in order, and drives `Write_register`/`Write_data`/`RegWrite` with the pulse spacing the register file requires. Optional forwarding ports let the decode stage see values still pending in the queue. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; must be a power of two and at least 2.
- `WIDTH`, 32: data width.
- `AW`, 5: register address width.

Ports:
- `clk`  in  1  the only clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_valid`  in  1  a load result is presented this cycle.
- `mem_rd`  in  AW  destination register of the load result.
- `mem_data`  in  WIDTH  load result data.
- `alu_valid`  in  1  an ALU result is presented this cycle.
- `alu_rd`  in  AW  destination register of the ALU result.
- `alu_data`  in  WIDTH  ALU result data.
- `in_ready`  out  1  both inputs may be accepted this cycle.
- `Write_register`  out  AW  register-file write address (registered).
- `Write_data`  out  WIDTH  register-file write data (registered).
- `RegWrite`  out  1  register-file write strobe (registered).
- `wbq_count`  out  log2(DEPTH)+1  number of entries queued, excluding the one on the outputs.
- `rs1`, `rs2`  in  AW  forwarding lookup addresses.
- `fwd_hit1`, `fwd_hit2`  out  1  a pending write matches `rs1`/`rs2`.
- `fwd_data1`, `fwd_data2`  out  WIDTH  data of the youngest matching pending write.

## Operation
- Reset: queue empty, `wbq_count`=0, `RegWrite`=0, `Write_register`=0, `Write_data`=0, gap phase cleared, `fwd_hit*`=0.
- `in_ready` = (`wbq_count` <= DEPTH-2). It is combinational from the current count and ignores a same-cycle dequeue.
- Enqueue happens on an edge where `in_ready`=1:
  - A valid mem entry is written first.
  - A valid alu entry is written second, so mem is older when both arrive together.
  - Valid inputs while `in_ready`=0 are dropped; upstream must stall.
- Register 0 is an ordinary register. Writes to it are queued and issued, not suppressed.
- Drain uses a two-phase machine: ISSUE and GAP.
  - ISSUE with queue non-empty: pop the head into `Write_register`/`Write_data`, set `RegWrite`=1, go to GAP.
  - ISSUE with queue empty: `RegWrite`=0, stay in ISSUE.
  - GAP: `RegWrite`=0, address and data hold, go to ISSUE.
  - Each write is therefore a one-cycle high pulse followed by at least one low cycle. The register file triggers on `RegWrite` edges, so back-to-back highs are forbidden.
- Enqueue and pop on the same edge are allowed. Count changes by (enqueued - popped).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Forwarding searches the queue entries plus the entry currently on the outputs while `RegWrite`=1.
  - The youngest match wins.
  - Lookup is combinational from state; the current cycle's inputs are not searched.
- Reset asserted mid-operation discards all pending entries and forces `RegWrite`=0 on the next edge. No partial write is completed.

## Timing
- Minimum latency: an entry accepted at edge N, with the queue empty and the FSM in ISSUE, gives `RegWrite`=1 in the cycle after edge N+1.
- Sustained drain rate: one write per 2 cycles. Sustained accept rate while not full: up to 2 per cycle.
- `Write_register`/`Write_data` are stable for the whole `RegWrite` high cycle and the following GAP cycle.
- `in_ready` is valid in the same cycle as `wbq_count`. There are no combinational paths from the `*_valid` inputs to any output.

## Configuration
- `WBQ_FWD_EN` defined: the forwarding comparators and muxes are built and behave as described above.
- `WBQ_FWD_EN` undefined:
  - `fwd_hit1`/`fwd_hit2` are constant 0 and `fwd_data1`/`fwd_data2` are constant 0.
  - `rs1`/`rs2` are ignored.
  - Queue and drain behaviour are unchanged.

## Test plan
- Reset, then a single alu entry (rd=3, data=0x0000_0006) at edge 1 -> `RegWrite` pulses high for exactly one cycle after edge 2 with `Write_register`=3 and data 0x6; `wbq_count` returns to 0.
- mem (rd=1, 0x9) and alu (rd=1, 0xA) in the same cycle -> writes issue in order 0x9 then 0xA, separated by one low cycle; with `WBQ_FWD_EN`, `rs1`=1 shows hit with 0xA while both are pending.
- Present dual inputs every cycle with DEPTH=4 -> `in_ready` drops once count reaches 3; no entry is lost or duplicated; issue order matches acceptance order across pointer wrap.
- Assert `rst` while 3 entries are pending and `RegWrite`=1 -> next edge gives `RegWrite`=0 and count 0; no further writes issue.
- Write to register 0 (data 0x1234) -> `RegWrite` pulses with `Write_register`=0; without `WBQ_FWD_EN`, `fwd_hit1`=0 for `rs1`=0 throughout.
